// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the pattern step sequencer.
//   state_t      : playback FSM states
//   step_entry_t : one table entry, absolute time offset plus {i2,i1}
//   sat_inc      : saturating increment used by the tick counter
package pattern_seq_pkg;

  localparam int DEF_NUM_STEPS = 12;
  localparam int DEF_IDX_W     = 4;
  localparam int STEP_TIME_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ofs: cycles after run start at which the entry may fire
  // bits: {i2,i1}
  typedef struct packed {
    logic [STEP_TIME_W-1:0] ofs;
    logic [1:0]             bits;
  } step_entry_t;

  function automatic logic [STEP_TIME_W-1:0] sat_inc(input logic [STEP_TIME_W-1:0] v);
    return (&v) ? v : v + STEP_TIME_W'(1);
  endfunction

endpackage

// File: rtl/pattern_step_table.sv
// Step table register file: one write port, one combinational read port.
//   clk, reset : clock, synchronous active-high reset (clears every entry)
//   we         : write strobe (caller gates it with busy)
//   waddr      : write index; indices >= NUM_STEPS are dropped
//   wdata      : entry to write
//   raddr      : read index; out-of-range reads return zero
//   rdata      : entry at raddr
module pattern_step_table
  import pattern_seq_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  step_entry_t      wdata,
  input  logic [IDX_W-1:0] raddr,
  output step_entry_t      rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  step_entry_t mem [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr <= LAST_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (raddr <= LAST_IDX) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/pattern_step_sequencer.sv
// Plays a programmable table of timed {i2,i1} steps onto the sequence
// detector inputs, with start/abort, optional looping and a per-step strobe.
//   clk, reset  : clock, synchronous active-high reset
//   cfg_we      : table write, honoured only while busy=0
//   cfg_addr    : table index (>= NUM_STEPS dropped)
//   cfg_time    : absolute offset in cycles after run start
//   cfg_bits    : {i2,i1} for the entry
//   start       : begin playback (ignored while busy)
//   abort       : return to IDLE, clearing outputs; beats everything else
//   loop_en     : restart at step 0 after the last step
//   i2, i1      : registered detector inputs
//   step_valid  : one-cycle pulse when i2/i1 take a new entry
//   step_idx    : index of the entry on i2/i1
//   busy        : high exactly while in RUN
//   done        : one-cycle pulse after a non-looping run completes
//   state_dbg   : current FSM state
//
// Strobe semantics: step_valid is a push-only strobe with no ready. It is
// high for exactly one cycle, in the cycle i2/i1/step_idx first show an
// entry; the consumer must sample in that cycle. done never coincides
// with step_valid.
//
// TIME_W must equal the width of step_entry_t.ofs in the package.
module pattern_step_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int TIME_W    = STEP_TIME_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [TIME_W-1:0] cfg_time,
  input  logic [1:0]        cfg_bits,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  output logic              i2,
  output logic              i1,
  output logic              step_valid,
  output logic [IDX_W-1:0]  step_idx,
  output logic              busy,
  output logic              done,
  output state_t            state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  state_t            state_q, state_n;
  logic [TIME_W-1:0] tcnt_q, tcnt_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [1:0]        bits_q, bits_n;
  logic              sv_q, sv_n;
  logic [IDX_W-1:0]  sidx_q, sidx_n;
  logic              done_q, done_n;
  step_entry_t       cur, wentry;

  assign wentry = '{ofs: cfg_time, bits: cfg_bits};

  pattern_step_table #(
    .NUM_STEPS(NUM_STEPS),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk  (clk),
    .reset(reset),
    .we   (cfg_we && !busy),
    .waddr(cfg_addr),
    .wdata(wentry),
    .raddr(idx_q),
    .rdata(cur)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      idx_q   <= '0;
      bits_q  <= '0;
      sv_q    <= 1'b0;
      sidx_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tcnt_q  <= tcnt_n;
      idx_q   <= idx_n;
      bits_q  <= bits_n;
      sv_q    <= sv_n;
      sidx_q  <= sidx_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    tcnt_n  = tcnt_q;
    idx_n   = idx_q;
    bits_n  = bits_q;
    sv_n    = 1'b0;
    sidx_n  = sidx_q;
    done_n  = 1'b0;
    if (abort) begin
      state_n = IDLE;
      tcnt_n  = '0;
      idx_n   = '0;
      bits_n  = '0;
      sidx_n  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_n = RUN;
            tcnt_n  = '0;
            idx_n   = '0;
          end
        end
        RUN: begin
          tcnt_n = sat_inc(tcnt_q);
          // One entry per cycle at most; a late entry fires as soon as
          // the counter has reached it, so backlogged entries slip.
          if (tcnt_q >= cur.ofs) begin
            bits_n = cur.bits;
            sidx_n = idx_q;
            sv_n   = 1'b1;
            if (idx_q == LAST_IDX) begin
              if (loop_en) begin
                tcnt_n = '0;
                idx_n  = '0;
              end else begin
                state_n = DONE;
              end
            end else begin
              idx_n = idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          // done is registered on the way out so it never overlaps the
          // final step_valid pulse.
          state_n = IDLE;
          done_n  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign i2         = bits_q[1];
  assign i1         = bits_q[0];
  assign step_valid = sv_q;
  assign step_idx   = sidx_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule
